// File: rtl/key_sched_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : key_sched_sequencer
// Purpose  : Captures the 11 AES-128 round keys produced by the word-serial key
//            schedule and streams them to the round datapath, one per block.
// Revision : 1.0  initial release
// ============================================================================

module key_sched_sequencer #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         first_data_in_flag,
    input  logic [31:0]  key_in0,
    input  logic [31:0]  key_in1,
    input  logic [31:0]  key_in2,
    input  logic [31:0]  key_in3,
    input  logic         key_flag,
    input  logic [31:0]  ks_key0,
    input  logic [31:0]  ks_key1,
    input  logic [31:0]  ks_key2,
    input  logic [31:0]  ks_key3,
    input  logic         blk_start,
    input  logic         rk_ready,
    output logic         busy,
    output logic         keys_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         last_round,
    output logic         blk_done,
    output logic         ks_err
);

    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      C_LAST    = 4'(NR);
    localparam logic [WD_W-1:0] C_WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_EXPAND = 2'd0,
        S_READY  = 2'd1,
        S_RUN    = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cap_cnt;
    logic [WD_W-1:0] r_wd_cnt;
    logic [127:0]    r_key0;
    logic [127:0]    r_keys [1:NR];
    logic            w_capture;
    logic            w_beat;

    assign w_capture = (r_state == S_EXPAND) && key_flag;
    assign w_beat    = rk_valid && rk_ready;

    // Round key 0 is the cipher key itself; it tracks key_in for as long as
    // the shared reset is held, mirroring how the schedule loads its words.
    always_ff @(posedge clk or posedge first_data_in_flag) begin
        if (first_data_in_flag) begin
            r_key0 <= {key_in0, key_in1, key_in2, key_in3};
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_keys[r_cap_cnt] <= {ks_key0, ks_key1, ks_key2, ks_key3};
        end
    end

    always_comb begin
        rk_out = r_key0;
        if ((rk_idx != 4'd0) && (rk_idx <= C_LAST)) begin
            rk_out = r_keys[rk_idx];
        end
    end

    assign last_round = rk_valid && (rk_idx == C_LAST);

    always_ff @(posedge clk or posedge first_data_in_flag) begin
        if (first_data_in_flag) begin
            r_state    <= S_EXPAND;
            r_cap_cnt  <= 4'd1;
            r_wd_cnt   <= '0;
            busy       <= 1'b1;
            keys_ready <= 1'b0;
            rk_valid   <= 1'b0;
            rk_idx     <= 4'd0;
            blk_done   <= 1'b0;
            ks_err     <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            case (r_state)
                S_EXPAND: begin
                    if (key_flag) begin
                        r_wd_cnt <= '0;
                        if (r_cap_cnt < C_LAST) begin
                            r_cap_cnt <= r_cap_cnt + 4'd1;
                        end
                        if (r_cap_cnt == C_LAST) begin
                            r_state    <= S_READY;
                            keys_ready <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end else begin
                        if (r_wd_cnt != C_WD_MAX) begin
                            r_wd_cnt <= r_wd_cnt + 1'b1;
                        end
                        // Error is flagged on the same cycle the count reaches TIMEOUT.
                        if (r_wd_cnt >= C_WD_LAST) begin
                            r_state    <= S_ERR;
                            ks_err     <= 1'b1;
                            busy       <= 1'b0;
                            keys_ready <= 1'b0;
                            rk_valid   <= 1'b0;
                        end
                    end
                end

                S_READY: begin
                    if (blk_start) begin
                        r_state  <= S_RUN;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        rk_idx   <= 4'd0;
                    end
                end

                S_RUN: begin
                    if (w_beat) begin
                        if (rk_idx == C_LAST) begin
                            r_state  <= S_READY;
                            busy     <= 1'b0;
                            rk_valid <= 1'b0;
                            rk_idx   <= 4'd0;
                            blk_done <= 1'b1;
                        end else begin
                            rk_idx <= rk_idx + 4'd1;
                        end
                    end
                end

                default: begin
                    r_state    <= S_ERR;
                    ks_err     <= 1'b1;
                    busy       <= 1'b0;
                    keys_ready <= 1'b0;
                    rk_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_sched_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_key_sched_sequencer
// Purpose  : Directed scoreboard bench for key_sched_sequencer with a
//            behavioural AES-128 key schedule driving key_flag/ks_key.
// Revision : 1.0  initial release
// ============================================================================

module tb_key_sched_sequencer;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    logic         clk;
    logic         first_data_in_flag;
    logic [127:0] key_word;
    logic [127:0] ks_word;
    logic [31:0]  key_in0, key_in1, key_in2, key_in3;
    logic [31:0]  ks_key0, ks_key1, ks_key2, ks_key3;
    logic         key_flag;
    logic         blk_start;
    logic         rk_ready;
    logic         busy, keys_ready, rk_valid, last_round, blk_done, ks_err;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk_model [0:10];
    exp_t         exp_q [$];
    int           n_vec;
    int           n_err;
    int           sched_n;
    int           pulse_limit;
    bit           fixed_on;
    bit           fixed10_on;
    logic [127:0] fixed_rk1;
    logic [127:0] fixed_rk10;

    assign key_in0 = key_word[127:96];
    assign key_in1 = key_word[95:64];
    assign key_in2 = key_word[63:32];
    assign key_in3 = key_word[31:0];
    assign ks_key0 = ks_word[127:96];
    assign ks_key1 = ks_word[95:64];
    assign ks_key2 = ks_word[63:32];
    assign ks_key3 = ks_word[31:0];

    key_sched_sequencer #(.NR(10), .TIMEOUT(8)) dut (
        .clk                (clk),
        .first_data_in_flag (first_data_in_flag),
        .key_in0            (key_in0),
        .key_in1            (key_in1),
        .key_in2            (key_in2),
        .key_in3            (key_in3),
        .key_flag           (key_flag),
        .ks_key0            (ks_key0),
        .ks_key1            (ks_key1),
        .ks_key2            (ks_key2),
        .ks_key3            (ks_key3),
        .blk_start          (blk_start),
        .rk_ready           (rk_ready),
        .busy               (busy),
        .keys_ready         (keys_ready),
        .rk_valid           (rk_valid),
        .rk_idx             (rk_idx),
        .rk_out             (rk_out),
        .last_round         (last_round),
        .blk_done           (blk_done),
        .ks_err             (ks_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic compute_keys(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_model[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; afterwards, drive the schedule model for the next edge.
    // Pulses land on edges 4,8,..; past the 10th the schedule re-expands with
    // deliberately corrupted words so a frozen buffer is observable.
    task automatic tick();
        int p;
        @(posedge clk);
        #1;
        if (first_data_in_flag) begin
            sched_n  = 0;
            key_flag = 1'b0;
        end else begin
            sched_n++;
            p = (sched_n + 1) / 4;
            if (((sched_n + 1) % 4 == 0) && (p <= pulse_limit)) begin
                key_flag = 1'b1;
                ks_word  = (p <= 10) ? rk_model[p] : ~rk_model[(p - 1) % 10 + 1];
            end else begin
                key_flag = 1'b0;
            end
        end
    endtask

    task automatic release_reset();
        first_data_in_flag = 1'b0;
        sched_n            = 0;
        key_flag           = 1'b0;
    endtask

    task automatic push11();
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            e.key = rk_model[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic expand_and_check(input bit poke_start);
        int n = 0;
        release_reset();
        while (!keys_ready && n < 80) begin
            blk_start = poke_start && (n >= 5) && (n < 8);
            tick();
            n++;
            if (!keys_ready) chk("expand_state", {busy, rk_valid, ks_err}, 3'b100);
        end
        blk_start = 1'b0;
        chk("keys_ready_cycle", n + 1, 41);
        chk("ready_idle", {busy, rk_valid, ks_err}, 3'b000);
    endtask

    task automatic run_block(input bit do_start, input int stall_at, input int stall_len,
                             input bit mid_start, input bit chain, input int exp_cycles);
        int   nrun   = 0;
        int   stalls = 0;
        int   guard  = 0;
        bit   done   = 1'b0;
        exp_t e;
        rk_ready = 1'b1;
        if (do_start) begin
            push11();
            blk_start = 1'b1;
            tick();
            blk_start = 1'b0;
        end
        while (!done && guard < 60) begin
            guard++;
            if (blk_done) begin
                done = 1'b1;
            end else begin
                chk("rk_valid", rk_valid, 1'b1);
                if (exp_q.size() == 0) begin
                    chk("sb_depth", exp_q.size(), 1);
                end else begin
                    e = exp_q[0];
                    chk("rk_idx", rk_idx, e.idx);
                    chk("rk_out", rk_out, e.key);
                    chk("last_round", last_round, e.idx == 4'd10);
                    if (fixed_on && rk_idx == 4'd1) chk("fixed_rk1", rk_out, fixed_rk1);
                    if (fixed10_on && rk_idx == 4'd10) chk("fixed_rk10", rk_out, fixed_rk10);
                end
                rk_ready = !((int'(rk_idx) == stall_at) && (stalls < stall_len));
                if (!rk_ready) stalls++;
                else if (exp_q.size() != 0) void'(exp_q.pop_front());
                blk_start = mid_start && (rk_idx == 4'd5);
                nrun++;
                tick();
            end
        end
        blk_start = 1'b0;
        rk_ready  = 1'b1;
        chk("blk_done_seen", done, 1'b1);
        chk("run_cycles", nrun, exp_cycles);
        chk("done_valid", rk_valid, 1'b0);
        if (chain) begin
            push11();
            blk_start = 1'b1;
            tick();
            blk_start = 1'b0;
            chk("chain_start", {rk_valid, rk_idx}, {1'b1, 4'd0});
        end else begin
            tick();
            chk("done_pulse_len", blk_done, 1'b0);
            chk("idle_after_done", rk_valid, 1'b0);
        end
    endtask

    initial begin
        int g;
        n_vec              = 0;
        n_err              = 0;
        sched_n            = 0;
        pulse_limit        = 1000;
        fixed_on           = 1'b0;
        fixed10_on         = 1'b0;
        fixed_rk1          = '0;
        fixed_rk10         = '0;
        first_data_in_flag = 1'b1;
        key_flag           = 1'b0;
        blk_start          = 1'b0;
        rk_ready           = 1'b1;
        ks_word            = '0;
        key_word           = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_f(8'(i));
        compute_keys(key_word);

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 1'b1);
        chk("rst_keys_ready", keys_ready, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_idx", rk_idx, 4'd0);
        chk("rst_last_round", last_round, 1'b0);
        chk("rst_blk_done", blk_done, 1'b0);
        chk("rst_ks_err", ks_err, 1'b0);
        chk("rst_rk_out", rk_out, key_word);

        // FIPS-197 expansion, with an early blk_start that must be ignored
        expand_and_check(1'b1);
        repeat (8) tick();
        chk("ready_hold", {keys_ready, rk_valid}, 2'b10);

        // Block stream without stalls, checked against published round keys
        fixed_on   = 1'b1;
        fixed10_on = 1'b1;
        fixed_rk1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        fixed_rk10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
        run_block(1'b1, -1, 0, 1'b0, 1'b0, 11);
        fixed_on   = 1'b0;
        fixed10_on = 1'b0;

        // Stall at idx 4, then restart coincident with blk_done
        run_block(1'b1, 4, 3, 1'b0, 1'b1, 14);
        // Chained block with a mid-run blk_start that must be ignored
        run_block(1'b0, -1, 0, 1'b1, 1'b0, 11);

        // Reset mid-RUN at idx 6 with a new key
        push11();
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        g = 0;
        while (rk_idx != 4'd6 && g < 20) begin
            tick();
            g++;
        end
        chk("abort_at_idx6", rk_idx, 4'd6);
        key_word           = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        first_data_in_flag = 1'b1;
        key_flag           = 1'b0;
        #1;
        chk("abort_valid", rk_valid, 1'b0);
        chk("abort_done", blk_done, 1'b0);
        chk("abort_idx", rk_idx, 4'd0);
        chk("abort_rk_out", rk_out, key_word);
        exp_q.delete();
        compute_keys(key_word);
        tick();
        chk("abort_no_done", blk_done, 1'b0);
        tick();
        expand_and_check(1'b0);
        fixed_on  = 1'b1;
        fixed_rk1 = 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe;
        run_block(1'b1, -1, 0, 1'b0, 1'b0, 11);
        fixed_on  = 1'b0;

        // Watchdog: schedule stops after its 3rd pulse
        first_data_in_flag = 1'b1;
        tick();
        tick();
        pulse_limit = 3;
        release_reset();
        repeat (19) tick();
        chk("wd_before", {ks_err, busy}, 2'b01);
        tick();
        chk("wd_err", ks_err, 1'b1);
        chk("wd_busy", busy, 1'b0);
        chk("wd_keys_ready", keys_ready, 1'b0);
        blk_start = 1'b1;
        repeat (6) tick();
        blk_start = 1'b0;
        chk("wd_sticky", ks_err, 1'b1);
        chk("wd_no_valid", rk_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_sched_sequencer.md
Name: key_sched_sequencer

Overview:
- Controller between the 32-bit-word key schedule and the AES round datapath.
- Tracks the schedule's expansion of one 128-bit cipher key by counting key_flag pulses, and stores round keys 0..10 in an internal 11-entry buffer.
- Once all keys are stored, it serves them to the cipher core, one round key per accepted beat, per block, through a start/valid/ready handshake.
- Includes a watchdog that flags a stalled schedule.

Parameters:
- NR, 10, number of AES rounds. Only 10 is supported because the schedule is AES-128 only.
- TIMEOUT, 8, maximum cycles allowed between key_flag pulses during expansion before the error state.

Ports:
- clk  in  1  clock.
- first_data_in_flag  in  1  asynchronous active-high reset; also starts a new key expansion (shared with key schedule).
- key_in0..key_in3  in  32 each  cipher key words, MSW first; same nets that feed the schedule.
- key_flag  in  1  one-cycle pulse from the schedule; a new round key is valid on ks_key0..3.
- ks_key0..ks_key3  in  32 each  schedule key_out0..3.
- blk_start  in  1  cipher core requests the key stream for one block.
- rk_ready  in  1  cipher core accepts the current rk_out.
- busy  out  1  high in EXPAND and RUN.
- keys_ready  out  1  all 11 round keys are stored.
- rk_valid  out  1  rk_out/rk_idx are valid.
- rk_idx  out  4  round index 0..10 of rk_out.
- rk_out  out  128  {w0,w1,w2,w3} of round key rk_idx.
- last_round  out  1  rk_valid and rk_idx==10.
- blk_done  out  1  one-cycle pulse after key 10 is accepted.
- ks_err  out  1  sticky watchdog error.

Behaviour:
- **Reset (first_data_in_flag high):**
  - State EXPAND; cap_cnt=1; wd_cnt=0.
  - Buffer[0] <= {key_in0..key_in3}, loaded asynchronously exactly as the schedule loads its words.
  - Outputs: busy=1, keys_ready=0, rk_valid=0, rk_idx=0, last_round=0, blk_done=0, ks_err=0.
  - Reset asserted mid-RUN aborts the block silently, with no blk_done.
- **EXPAND:**
  - Each cycle with key_flag=1: buffer[cap_cnt] <= {ks_key0..3}; cap_cnt increments; wd_cnt clears.
  - Otherwise wd_cnt increments.
  - The schedule ignores its own round output; the count comes solely from key_flag pulses.
  - Nominal timing: pulses arrive 4 cycles apart, the 10th at cycle 40 after reset release.
  - On the capture with cap_cnt==10: next state READY, and keys_ready=1 from the following cycle.
  - wd_cnt reaching TIMEOUT: state ERR.
  - blk_start is ignored.
- **READY:**
  - Subsequent key_flag pulses are ignored; the schedule re-expands endlessly and the buffer is frozen until the next reset.
  - blk_start=1: the next cycle enters RUN with rk_idx=0 and rk_valid=1.
- **RUN:**
  - rk_out is driven combinationally from buffer[rk_idx].
  - A beat transfers when rk_valid && rk_ready.
  - On transfer with rk_idx<10: rk_idx increments next cycle.
  - On transfer with rk_idx==10: next cycle rk_valid=0, blk_done=1 (one cycle), rk_idx=0, state READY.
  - rk_ready low: rk_idx and rk_out are held (stall, no limit).
  - blk_start during RUN is ignored.
  - blk_start in the same cycle as blk_done is honoured; RUN restarts the following cycle.
  - Throughput: 11 cycles per block at rk_ready=1, plus 1 cycle in READY.
- **ERR:**
  - ks_err=1, busy=0, keys_ready=0, rk_valid=0.
  - Exit only via reset.
- **Encoding:** 2-bit state {EXPAND, READY, RUN, ERR}. An illegal state decodes to ERR.
- **Counters:**
  - cap_cnt is 4-bit and saturates at 10.
  - wd_cnt has width clog2(TIMEOUT+1) and saturates.

Test Plan:
- **FIPS-197 expansion:**
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c; reset pulse; then run the real schedule.
  - Required: keys_ready rises 41 cycles after reset release.
  - Required: buffer[1]=a0fafe17 88542cb1 23a33939 2a6c7605.
  - Required: buffer[10]=d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- **Block stream, no stalls:**
  - Stimulus: blk_start one cycle in READY, rk_ready=1.
  - Required: rk_idx 0..10 on 11 consecutive cycles; last_round only at idx 10; blk_done pulse the next cycle; rk_out at idx 0 = cipher key.
- **Stalls:**
  - Stimulus: rk_ready low 3 cycles at idx 4.
  - Required: rk_idx and rk_out stable for those cycles; total 14 cycles to blk_done.
- **Early and back-to-back starts:**
  - Stimulus: blk_start during EXPAND and mid-RUN.
  - Required: both ignored.
  - Stimulus: blk_start coincident with blk_done.
  - Required: new RUN begins with idx 0 the next cycle.
- **Watchdog:**
  - Stimulus: force key_flag low after the 3rd pulse.
  - Required: ks_err=1 on the cycle wd_cnt reaches 8; it stays high; rk_valid stays 0 until reset.
- **Reset mid-RUN:**
  - Stimulus: assert first_data_in_flag at idx 6 with a new key 000102..0f.
  - Required: rk_valid drops immediately (async); no blk_done; re-expansion stores buffer[1]=d6aa74fd d2af72fa daa678f1 d6ab76fe.
